// File: rtl/pwm_capture.sv
// PWM / L298 direction monitor: measures period, high time and duty of a PWM line.
// Define PWM_CAP_GLITCH_FILTER_EN to add a FILT_LEN-cycle stability filter after the synchronizers.
module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int LOCK_CNT = 2,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             dir_a,
  input  logic             dir_b,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [6:0]       duty_pct,
  output logic             meas_valid,
  output logic             locked,
  output logic             stuck,
  output logic             overrun,
  output logic [1:0]       dir
);

  localparam int DW = CNT_W + 7;
  localparam int SW = $clog2(DW + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [SW-1:0]    STEPS_LEFT = SW'(DW - 1);
  localparam logic [RW-1:0]    RUN_MAX    = RW'(LOCK_CNT);
  localparam logic [RW-1:0]    RUN_LOCK   = RW'(LOCK_CNT - 1);

`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic [2:0]       sync_1, sync_2, clean;
  logic             pwm_s, pwm_d, rise, fall, timeout, same_per;
  logic [CNT_W-1:0] period_cnt, high_cnt, high_lat, idle_cnt;
  logic             busy;
  logic [SW-1:0]    step_cnt;
  logic [CNT_W-1:0] rem, den, pend_high;
  logic [DW-1:0]    acc;
  logic [RW-1:0]    run_len;
  logic [CNT_W+DW-1:0] step_res, load_res;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // One restoring-division step: returns {remainder, shifted dividend/quotient}.
  function automatic logic [CNT_W+DW-1:0] div_step(input logic [CNT_W-1:0] r,
                                                    input logic [DW-1:0]    a,
                                                    input logic [CNT_W-1:0] d);
    logic [CNT_W:0] t;
    t = {r, a[DW-1]};
    if (t >= {1'b0, d})
      return {CNT_W'(t - {1'b0, d}), a[DW-2:0], 1'b1};
    else
      return {t[CNT_W-1:0], a[DW-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {dir_b, dir_a, pwm_in};
      sync_2 <= sync_1;
    end
  end

  generate
    if (FILT_EN && FILT_LEN > 0) begin : g_filter
      localparam int FW = $clog2(FILT_LEN + 1);
      for (genvar i = 0; i < 3; i++) begin : g_bit
        logic [FW-1:0] cnt;
        logic          level;
        always_ff @(posedge clk) begin
          if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
          end else if (sync_2[i] == level) begin
            cnt <= '0;
          end else if (cnt == FW'(FILT_LEN - 1)) begin
            cnt   <= '0;
            level <= sync_2[i];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        assign clean[i] = level;
      end
    end else begin : g_nofilter
      assign clean = sync_2;
    end
  endgenerate

  assign pwm_s    = clean[0];
  assign rise     = pwm_s & ~pwm_d;
  assign fall     = ~pwm_s & pwm_d;
  assign timeout  = !(rise || fall) && !stuck && (idle_cnt == TO_LAST);
  assign same_per = (run_len != '0) && (den == period);
  assign step_res = div_step(rem, acc, den);
  assign load_res = div_step('0, DW'(high_lat) * DW'(100), period_cnt);

  always_ff @(posedge clk) begin
    if (rst) dir <= 2'b00;
    else     dir <= clean[2:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pwm_d      <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_lat   <= '0;
      idle_cnt   <= '0;
      busy       <= 1'b0;
      step_cnt   <= '0;
      rem        <= '0;
      acc        <= '0;
      den        <= '0;
      pend_high  <= '0;
      run_len    <= '0;
      period     <= '0;
      high_time  <= '0;
      duty_pct   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pwm_d      <= pwm_s;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      idle_cnt   <= (rise || fall) ? '0 : sat_inc(idle_cnt);

      // Busy stays high through the publish cycle so a rise landing there is dropped.
      if (busy) begin
        if (step_cnt != '0) begin
          {rem, acc} <= step_res;
          step_cnt   <= step_cnt - 1'b1;
          if (step_cnt == SW'(1)) begin
            period     <= den;
            high_time  <= pend_high;
            duty_pct   <= step_res[6:0];
            meas_valid <= 1'b1;
            run_len    <= same_per ? ((run_len == RUN_MAX) ? run_len : run_len + 1'b1) : RW'(1);
            locked     <= (LOCK_CNT <= 1) || (same_per && run_len >= RUN_LOCK);
          end
        end else begin
          busy <= 1'b0;
        end
      end

      if (timeout) begin
        state      <= IDLE;
        busy       <= 1'b0;
        step_cnt   <= '0;
        period     <= '0;
        high_time  <= '0;
        duty_pct   <= pwm_s ? 7'd100 : 7'd0;
        meas_valid <= 1'b1;
        locked     <= 1'b0;
        run_len    <= '0;
        stuck      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state      <= HIGH;
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              stuck      <= 1'b0;
            end
          end
          HIGH: begin
            period_cnt <= sat_inc(period_cnt);
            if (fall) begin
              high_lat <= high_cnt;
              state    <= LOW;
            end else begin
              high_cnt <= sat_inc(high_cnt);
            end
          end
          LOW: begin
            if (rise) begin
              state      <= HIGH;
              period_cnt <= CNT_W'(1);
              high_cnt   <= CNT_W'(1);
              if (busy) begin
                overrun <= 1'b1;
              end else begin
                {rem, acc} <= load_res;
                den        <= period_cnt;
                pend_high  <= high_lat;
                step_cnt   <= STEPS_LEFT;
                busy       <= 1'b1;
              end
            end else begin
              period_cnt <= sat_inc(period_cnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a waveform-level model predicts each published
// measurement (including divider-busy drops) and the monitor collects what the DUT reports.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = CNT_W + 7;

  logic             clk = 1'b0;
  logic             rst, pwm_in, dir_a, dir_b;
  logic [CNT_W-1:0] period, high_time;
  logic [6:0]       duty_pct;
  logic             meas_valid, locked, stuck, overrun;
  logic [1:0]       dir;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_CNT(2), .FILT_LEN(4)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .dir_a(dir_a), .dir_b(dir_b),
    .period(period), .high_time(high_time), .duty_pct(duty_pct), .meas_valid(meas_valid),
    .locked(locked), .stuck(stuck), .overrun(overrun), .dir(dir)
  );

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
    logic [6:0]  duty;
    logic        stuck;
    logic        locked;
  } meas_t;

  meas_t exp_q[$];
  meas_t obs_q[$];
  meas_t mon_m;
  int    checks = 0, failures = 0, cyc = 0;
  int    ovr_seen = 0, ovr_exp = 0;
  bit    have_prev, have_pub;
  int    prev_per, prev_hi, last_acc, last_pub;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (meas_valid) begin
        mon_m.per    = period;
        mon_m.hi     = high_time;
        mon_m.duty   = duty_pct;
        mon_m.stuck  = stuck;
        mon_m.locked = locked;
        obs_q.push_back(mon_m);
      end
      if (overrun) ovr_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; pwm_in = 1'b0; dir_a = 1'b0; dir_b = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    have_prev = 0; have_pub = 0; last_acc = -100000; last_pub = 0;
    ovr_seen = 0; ovr_exp = 0;
    tick();
  endtask

  // Each rise closes the previous period; accepted only if the divider has been free for LAT+1 cycles.
  task automatic drive_period(input int per, input int hi);
    meas_t e;
    if (have_prev) begin
      if (cyc - last_acc >= LAT + 1) begin
        e.per    = 16'(prev_per);
        e.hi     = 16'(prev_hi);
        e.duty   = 7'(prev_hi * 100 / prev_per);
        e.stuck  = 1'b0;
        e.locked = have_pub && (last_pub == prev_per);
        exp_q.push_back(e);
        have_pub = 1; last_pub = prev_per; last_acc = cyc;
      end else begin
        ovr_exp++;
      end
    end
    have_prev = 1; prev_per = per; prev_hi = hi;
    pwm_in = 1'b1;
    repeat (hi) tick();
    pwm_in = 1'b0;
    repeat (per - hi) tick();
  endtask

  task automatic wait_meas(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (obs_q.size() >= n) ok = 1;
      else tick();
    end
    if (obs_q.size() >= n) ok = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (period !== 16'd0) begin failures++; $display("[TB] FAIL reset_period got=%0d want=0", period); end
    checks++; if (high_time !== 16'd0) begin failures++; $display("[TB] FAIL reset_high got=%0d want=0", high_time); end
    checks++; if (duty_pct !== 7'd0) begin failures++; $display("[TB] FAIL reset_duty got=%0d want=0", duty_pct); end
    checks++; if ({meas_valid, locked, stuck, overrun} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_flags got=%b want=0000", {meas_valid, locked, stuck, overrun});
    end
    checks++; if (dir !== 2'b00) begin failures++; $display("[TB] FAIL reset_dir got=%b want=00", dir); end
  endtask

  task automatic test_basic();
    bit ok; int n; meas_t e, o;
    apply_reset();
    dir_a = 1'b1; dir_b = 1'b0;
    repeat (3) drive_period(10, 3);
    n = exp_q.size();
    wait_meas(n, 80, ok);
    repeat (30) tick();
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_wait got=%0d meas want=%0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL basic_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL basic_extra got=%0d extra want=0", obs_q.size()); end
    checks++; if (ovr_seen != ovr_exp) begin failures++; $display("[TB] FAIL basic_overrun got=%0d want=%0d", ovr_seen, ovr_exp); end
    checks++; if (dir !== 2'b01) begin failures++; $display("[TB] FAIL basic_dir got=%b want=01", dir); end
  endtask

  task automatic test_lock();
    bit ok; int n; meas_t e, o;
    apply_reset();
    repeat (5) drive_period(10, 3);
    repeat (4) drive_period(20, 5);
    n = exp_q.size();
    wait_meas(n, 80, ok);
    repeat (30) tick();
    checks++; if (!ok) begin failures++; $display("[TB] FAIL lock_wait got=%0d meas want=%0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL lock_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL lock_extra got=%0d extra want=0", obs_q.size()); end
    checks++; if (ovr_seen != ovr_exp) begin failures++; $display("[TB] FAIL lock_overrun got=%0d want=%0d", ovr_seen, ovr_exp); end
  endtask

  task automatic test_back_to_back();
    bit ok; int n; meas_t e, o;
    apply_reset();
    repeat (4) drive_period(24, 12);
    repeat (5) drive_period(23, 11);
    n = exp_q.size();
    wait_meas(n, 80, ok);
    repeat (30) tick();
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_wait got=%0d meas want=%0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL b2b_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL b2b_extra got=%0d extra want=0", obs_q.size()); end
    checks++; if (ovr_seen != ovr_exp) begin failures++; $display("[TB] FAIL b2b_overrun got=%0d want=%0d", ovr_seen, ovr_exp); end
  endtask

  task automatic test_dir();
    bit       a_pat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit       b_pat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit [1:0] want  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    bit [1:0] old;
    apply_reset();
    old = 2'b00;
    for (int i = 0; i < 4; i++) begin
      dir_a = a_pat[i]; dir_b = b_pat[i];
      tick(); tick();
      checks++; if (dir !== old) begin failures++; $display("[TB] FAIL dir_early[%0d] got=%b want=%b", i, dir, old); end
      tick();
      checks++; if (dir !== want[i]) begin failures++; $display("[TB] FAIL dir[%0d] got=%b want=%b", i, dir, want[i]); end
      old = want[i];
    end
  endtask

  task automatic test_timeout_high();
    meas_t e, o;
    apply_reset();
    e.per = 16'd0; e.hi = 16'd0; e.duty = 7'd100; e.stuck = 1'b1; e.locked = 1'b0;
    exp_q.push_back(e);
    pwm_in = 1'b1;
    repeat (1200) tick();
    checks++; if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL to_high_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL to_high_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    checks++; if (stuck !== 1'b1) begin failures++; $display("[TB] FAIL to_high_stuck got=%b want=1", stuck); end
  endtask

  task automatic test_timeout_low();
    meas_t e, o;
    apply_reset();
    e.per = 16'd0; e.hi = 16'd0; e.duty = 7'd0; e.stuck = 1'b1; e.locked = 1'b0;
    exp_q.push_back(e);
    repeat (1100) tick();
    checks++; if (obs_q.size() != 1) begin failures++; $display("[TB] FAIL to_low_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL to_low_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    checks++; if (stuck !== 1'b1) begin failures++; $display("[TB] FAIL to_low_stuck got=%b want=1", stuck); end
    pwm_in = 1'b1;
    repeat (5) tick();
    checks++; if (stuck !== 1'b0) begin failures++; $display("[TB] FAIL to_low_clear got=%b want=0", stuck); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n; meas_t e, o;
    apply_reset();
    pwm_in = 1'b1;
    repeat (10) tick();
    apply_reset();
    repeat (40) tick();
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL rst_high_meas got=%0d want=0", obs_q.size()); end
    repeat (2) drive_period(50, 25);
    n = exp_q.size();
    wait_meas(n, 80, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL rst_wait got=%0d meas want=%0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL rst_meas got per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b want per=%0d hi=%0d duty=%0d stuck=%0b lock=%0b",
                 o.per, o.hi, o.duty, o.stuck, o.locked, e.per, e.hi, e.duty, e.stuck, e.locked);
      end
    end
    pwm_in = 1'b1;
    repeat (5) tick();
    apply_reset();
    repeat (40) tick();
    checks++; if (obs_q.size() != 0) begin failures++; $display("[TB] FAIL rst_divide_meas got=%0d want=0", obs_q.size()); end
  endtask

  initial begin
    rst = 1'b1; pwm_in = 1'b0; dir_a = 1'b0; dir_b = 1'b0;
    test_reset();
    test_basic();
    test_lock();
    test_back_to_back();
    test_dir();
    test_timeout_high();
    test_timeout_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
